// File: rtl/spi_reg_responder_pkg.sv
// Shared types and constants for the SPI register responder.
package spi_pkg;

    localparam int unsigned NUM_REGS_DEF  = 4;
    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned MODE_W        = 2;
    localparam int unsigned MODE_CPOL_BIT = 1;
    localparam int unsigned MODE_CPHA_BIT = 0;
    localparam int unsigned RW_BIT        = 7;
    localparam int unsigned ADDR_LSB      = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        WRITE = 2'd2,
        READ  = 2'd3
    } state_t;

    // Modes 0 and 3 sample on the rising SCLK edge, modes 1 and 2 on the falling one.
    function automatic logic sample_on_rise(input logic [MODE_W-1:0] mode);
        return mode[MODE_CPOL_BIT] == mode[MODE_CPHA_BIT];
    endfunction

endpackage

// File: rtl/spi_reg_responder_if.sv
// SPI pins plus register-file side outputs of the responder.
interface spi_reg_responder_if
    import spi_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEF
);
    localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [MODE_W-1:0]          MODE;
    logic                       SCLK;
    logic                       CS;
    logic                       MOSI;
    logic                       MISO;
    logic                       wr_en;
    logic [AW-1:0]              wr_addr;
    logic [BYTE_W-1:0]          wr_data;
    logic [BYTE_W*NUM_REGS-1:0] regs_o;
    logic                       frame_done;
    logic                       busy;

    modport master (
        output MODE, SCLK, CS, MOSI,
        input  MISO, wr_en, wr_addr, wr_data, regs_o, frame_done, busy
    );

    modport slave (
        input  MODE, SCLK, CS, MOSI,
        output MISO, wr_en, wr_addr, wr_data, regs_o, frame_done, busy
    );

endinterface

// File: rtl/spi_reg_responder_edge_sync.sv
// Multi-flop synchronizer with single-clk rise/fall pulses on the synchronized level.
module spi_edge_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    input  logic idle_level,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= {STAGES{idle_level}};
            prev_q <= idle_level;
        end else begin
            sync_q <= STAGES'({sync_q, async_in});
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_c = sync_q[STAGES-1] & ~prev_q;
    assign fall_c = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_reg_responder.sv
// SPI target exposing a small 8-bit register file: {RW,addr} byte, then burst write or read.
module spi_reg_responder
    import spi_pkg::*;
#(
    parameter int unsigned NUM_REGS    = NUM_REGS_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    spi_reg_responder_if.slave    bus
);

    localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic sclk_rise_c, sclk_fall_c, cs_rise_c, cs_fall_c;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic mosi_s;

    state_t            state_q, state_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0] rx_q, rx_d, tx_q, tx_d, rx_next;
    logic [AW-1:0]     ptr_q, ptr_d, ptr_inc;
    logic [BYTE_W-1:0] regs_q [NUM_REGS];
    logic [BYTE_W-1:0] regs_d [NUM_REGS];
    logic              byte_seen_q, byte_seen_d;
    logic              miso_q, miso_d;
    logic              wr_en_q, wr_en_d;
    logic [AW-1:0]     wr_addr_q, wr_addr_d;
    logic [BYTE_W-1:0] wr_data_q, wr_data_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q, busy_d;
    logic              sample_c, shift_c;

    spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk        (clk),
        .reset      (reset),
        .async_in   (bus.SCLK),
        .idle_level (bus.MODE[MODE_CPOL_BIT]),
        .rise_c     (sclk_rise_c),
        .fall_c     (sclk_fall_c)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk        (clk),
        .reset      (reset),
        .async_in   (bus.CS),
        .idle_level (1'b1),
        .rise_c     (cs_rise_c),
        .fall_c     (cs_fall_c)
    );

    // MOSI goes through the same depth as SCLK so data and edge stay aligned.
    always_ff @(posedge clk) begin
        if (!reset) mosi_q <= '0;
        else        mosi_q <= SYNC_STAGES'({mosi_q, bus.MOSI});
    end
    assign mosi_s = mosi_q[SYNC_STAGES-1];

    assign sample_c = sample_on_rise(mode_q) ? sclk_rise_c : sclk_fall_c;
    assign shift_c  = sample_on_rise(mode_q) ? sclk_fall_c : sclk_rise_c;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            mode_q       <= '0;
            bit_cnt_q    <= '0;
            rx_q         <= '0;
            tx_q         <= '0;
            ptr_q        <= '0;
            regs_q       <= '{default: '0};
            byte_seen_q  <= 1'b0;
            miso_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_q         <= rx_d;
            tx_q         <= tx_d;
            ptr_q        <= ptr_d;
            regs_q       <= regs_d;
            byte_seen_q  <= byte_seen_d;
            miso_q       <= miso_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        bit_cnt_d    = bit_cnt_q;
        rx_d         = rx_q;
        tx_d         = tx_q;
        ptr_d        = ptr_q;
        regs_d       = regs_q;
        byte_seen_d  = byte_seen_q;
        miso_d       = miso_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        rx_next      = {rx_q[BYTE_W-2:0], mosi_s};
        ptr_inc      = ptr_q + AW'(1);

        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                // A fall and rise on the same clk is a glitch, not a frame.
                if (cs_fall_c && !cs_rise_c) begin
                    state_d     = ADDR;
                    mode_d      = bus.MODE;
                    bit_cnt_d   = '0;
                    rx_d        = '0;
                    tx_d        = '0;
                    byte_seen_d = 1'b0;
                end
            end
            default: begin
                if (cs_rise_c) begin
                    state_d      = IDLE;
                    miso_d       = 1'b0;
                    frame_done_d = byte_seen_q;
                end else if (sample_c) begin
                    rx_d      = rx_next;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_seen_d = 1'b1;
                        case (state_q)
                            ADDR: begin
                                ptr_d = rx_next[ADDR_LSB +: AW];
                                if (rx_next[RW_BIT]) begin
                                    state_d = WRITE;
                                end else begin
                                    state_d = READ;
                                    tx_d    = regs_q[rx_next[ADDR_LSB +: AW]];
                                end
                            end
                            WRITE: begin
                                regs_d[ptr_q] = rx_next;
                                wr_en_d       = 1'b1;
                                wr_addr_d     = ptr_q;
                                wr_data_d     = rx_next;
                                ptr_d         = ptr_inc;
                            end
                            default: begin
                                ptr_d = ptr_inc;
                                tx_d  = regs_q[ptr_inc];
                            end
                        endcase
                    end
                end else if (shift_c) begin
                    if (state_q == READ) begin
                        miso_d = tx_q[BYTE_W-1];
                        tx_d   = {tx_q[BYTE_W-2:0], 1'b0};
                    end else begin
                        miso_d = 1'b0;
                    end
                end
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.MISO       = miso_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
        assign bus.regs_o[g*BYTE_W +: BYTE_W] = regs_q[g];
    end

endmodule

// File: tb/tb_spi_reg_responder.sv
// Bench for spi_reg_responder: SPI master driver, register-file reference model and scoreboard.
module tb_spi_reg_responder;

    localparam int unsigned NR = 4;
    localparam int unsigned SS = 2;
    localparam int unsigned H  = 5;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [1:0] a;
        logic [7:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_reg_responder_if #(.NUM_REGS(NR)) bus ();

    spi_reg_responder #(.NUM_REGS(NR), .SYNC_STAGES(SS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mregs [NR];
    wr_t        exp_wr[$];
    bit         exp_fd[$];
    logic [7:0] exp_rd[$];
    logic [7:0] act_rd[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic bq_t mk(input int n, input logic [7:0] b0 = 0, input logic [7:0] b1 = 0,
                               input logic [7:0] b2 = 0, input logic [7:0] b3 = 0,
                               input logic [7:0] b4 = 0, input logic [7:0] b5 = 0);
        bq_t r;
        logic [7:0] a [6];
        a = '{b0, b1, b2, b3, b4, b5};
        for (int i = 0; i < n; i++) r.push_back(a[i]);
        return r;
    endfunction

    function automatic logic [31:0] model_image();
        logic [31:0] v;
        for (int i = 0; i < NR; i++) v[i*8 +: 8] = mregs[i];
        return v;
    endfunction

    // Scoreboard: pops expectations whenever the DUT presents a write, a frame end or a read byte.
    always @(negedge clk) begin
        wr_t e;
        logic [7:0] r;
        if (bus.wr_en === 1'b1) begin
            if (exp_wr.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL wr_en: unexpected pulse addr=%0d data=%02h, none expected", bus.wr_addr, bus.wr_data);
            end else begin
                e = exp_wr.pop_front();
                chk("wr_addr", 32'(bus.wr_addr), 32'(e.a));
                chk("wr_data", 32'(bus.wr_data), 32'(e.d));
            end
        end
        if (bus.frame_done === 1'b1) begin
            n_cmp++;
            if (exp_fd.size() == 0) begin
                n_bad++;
                $display("FAIL frame_done: unexpected pulse, none expected at %0t", $time);
            end else begin
                void'(exp_fd.pop_front());
            end
        end
        while (act_rd.size() > 0) begin
            r = act_rd.pop_front();
            if (exp_rd.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL miso_byte: got %02h with no expected byte", r);
            end else begin
                chk("miso_byte", 32'(r), 32'(exp_rd.pop_front()));
            end
        end
    end

    // Drives one CS-low frame: full bytes, then optional partial bits, optionally aborted by reset.
    task automatic run_frame(input logic [1:0] mode, input bq_t bytes, input int partial, input bit abort_rst);
        logic cpol, cpha, b, m, rw;
        logic [1:0] ptr;
        logic [7:0] cur;
        int nb, total;
        cpol = mode[1];
        cpha = mode[0];
        nb   = bytes.size();
        cur  = '0;

        if (nb > 0) begin
            rw  = bytes[0][7];
            ptr = bytes[0][1:0];
            exp_rd.push_back(8'h00);
            for (int k = 1; k < nb; k++) begin
                if (rw) begin
                    mregs[ptr] = bytes[k];
                    exp_wr.push_back('{a: ptr, d: bytes[k]});
                    exp_rd.push_back(8'h00);
                end else begin
                    exp_rd.push_back(mregs[ptr]);
                end
                ptr = ptr + 2'd1;
            end
            if (!abort_rst) exp_fd.push_back(1'b1);
        end

        bus.MODE = mode;
        bus.SCLK = cpol;
        wait_clk(10);
        bus.CS = 1'b0;
        wait_clk(H);

        total = 8 * nb + partial;
        for (int i = 0; i < total; i++) begin
            if (i / 8 < nb) b = bytes[i/8][7 - (i % 8)];
            else            b = 1'($urandom_range(0, 1));
            if (!cpha) begin
                bus.MOSI = b;
                wait_clk(H);
                m = bus.MISO;
                bus.SCLK = ~cpol;
                wait_clk(H);
                bus.SCLK = cpol;
            end else begin
                bus.SCLK = ~cpol;
                bus.MOSI = b;
                wait_clk(H);
                m = bus.MISO;
                bus.SCLK = cpol;
                wait_clk(H);
            end
            cur = {cur[6:0], m};
            if ((i % 8 == 7) && (i / 8 < nb)) act_rd.push_back(cur);
        end
        wait_clk(H);
        chk("busy_in_frame", 32'(bus.busy), 32'd1);

        if (abort_rst) begin
            reset = 1'b0;
            wait_clk(1);
            chk("miso_after_reset", 32'(bus.MISO), 32'd0);
            chk("regs_after_reset", bus.regs_o, 32'd0);
            chk("busy_after_reset", 32'(bus.busy), 32'd0);
            for (int i = 0; i < NR; i++) mregs[i] = 8'h00;
            bus.CS = 1'b1;
            wait_clk(4);
            reset = 1'b1;
        end else begin
            bus.CS = 1'b1;
        end
        wait_clk(12);

        chk("busy_idle", 32'(bus.busy), 32'd0);
        chk("pending_wr", 32'(exp_wr.size()), 32'd0);
        chk("pending_frame_done", 32'(exp_fd.size()), 32'd0);
        chk("pending_miso_bytes", 32'(exp_rd.size()), 32'd0);
        chk("regs_o", bus.regs_o, model_image());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bq_t q;
        int nb, partial;
        logic [1:0] mode;

        for (int i = 0; i < NR; i++) mregs[i] = 8'h00;
        reset    = 1'b0;
        bus.CS   = 1'b1;
        bus.SCLK = 1'b0;
        bus.MOSI = 1'b0;
        bus.MODE = 2'd0;
        wait_clk(5);
        chk("rst_miso", 32'(bus.MISO), 32'd0);
        chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
        chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_regs", bus.regs_o, 32'd0);
        reset = 1'b1;
        wait_clk(5);

        // Single write in mode 0.
        run_frame(2'd0, mk(2, 8'h80, 8'hA5), 0, 1'b0);

        // Preload then read back with pointer wrap, mode 3.
        run_frame(2'd3, mk(5, 8'h80, 8'h11, 8'h22, 8'h33, 8'h44), 0, 1'b0);
        run_frame(2'd3, mk(4, 8'h02, 8'hFF, 8'h00, 8'h5A), 0, 1'b0);

        // Wrapping write bursts in modes 1 and 2.
        run_frame(2'd1, mk(6, 8'h81, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05), 0, 1'b0);
        run_frame(2'd2, mk(6, 8'h81, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05), 0, 1'b0);

        // Partial data byte is dropped but the frame still completes.
        run_frame(2'd0, mk(1, 8'h80), 5, 1'b0);

        // Reset in the middle of a read, then a fresh read of the cleared file.
        run_frame(2'd0, mk(1, 8'h01), 5, 1'b1);
        run_frame(2'd0, mk(2, 8'h00, 8'hC3), 0, 1'b0);

        // SCLK activity with CS high must be ignored.
        run_frame(2'd0, mk(5, 8'h80, 8'h9A, 8'hBC, 8'hDE, 8'hF0), 0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            bus.SCLK = ~bus.SCLK;
            bus.MOSI = 1'($urandom_range(0, 1));
            wait_clk(H);
        end
        bus.SCLK = 1'b0;
        wait_clk(H);
        run_frame(2'd0, mk(2, 8'h83, 8'h7E), 0, 1'b0);

        // Randomized frames: mode, direction, address (upper bits included), length, partial tail.
        for (int f = 0; f < 24; f++) begin
            mode = 2'($urandom_range(0, 3));
            nb   = $urandom_range(0, 6);
            q.delete();
            for (int k = 0; k < nb; k++) q.push_back(8'($urandom_range(0, 255)));
            partial = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
            if (nb == 0) partial = $urandom_range(1, 7);
            run_frame(mode, q, partial, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_reg_responder.md
SPI_REG_RESPONDER -- requirements
Module: spi_reg_responder

Interface
REQ-001 Parameter: NUM_REGS, 4, number of 8-bit registers (power of two; address bits = log2(NUM_REGS)).
REQ-002 Parameter: SYNC_STAGES, 2, synchronizer depth for SCLK, CS and MOSI.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 MODE  input  2  {CPOL,CPHA}; sampled only while CS is high.
REQ-006 SCLK  input  1  serial clock from the initiator, asynchronous to clk.
REQ-007 CS  input  1  active-low chip select.
REQ-008 MOSI  input  1  serial data in, MSB first.
REQ-009 MISO  output  1  serial data out, MSB first, registered.
REQ-010 wr_en  output  1  one-clk pulse per completed write byte.
REQ-011 wr_addr  output  2  register index of the current wr_en.
REQ-012 wr_data  output  8  byte written on the current wr_en.
REQ-013 regs_o  output  32  register file image, reg[i] at bits [8i+7:8i].
REQ-014 frame_done  output  1  one-clk pulse when CS deasserts after at least one full byte.
REQ-015 busy  output  1  high from CS fall to CS rise.

Function
REQ-016 SCLK, CS and MOSI SHALL pass through SYNC_STAGES flops; edges are detected on the synchronized SCLK; SCLK period SHALL be at least 8 clk.
REQ-017 Sample edge SHALL be rising for modes 0 and 3 and falling for modes 1 and 2; the opposite edge is the shift edge.
REQ-018 MODE SHALL be latched at CS fall and held for the frame.
REQ-019 FSM states SHALL be IDLE, ADDR, WRITE, READ.
REQ-020 IDLE -> ADDR on synchronized CS fall; bit counter and tx shift register cleared to 0.
REQ-021 Each sample edge SHALL shift MOSI into an 8-bit rx shift register and increment a 3-bit bit counter (wraps 7 -> 0).
REQ-022 In ADDR, on the 8th sample edge, byte {RW, addr[6:0]} SHALL be decoded: the pointer takes addr[1:0] and addr[6:2] is ignored; RW=1 -> WRITE; RW=0 -> READ, with reg[pointer] loaded into the tx shift register on that same clk.
REQ-023 In WRITE, every 8th sample edge SHALL write the rx byte to reg[pointer], pulse wr_en with wr_addr=pointer and wr_data=byte, and increment the pointer modulo NUM_REGS.
REQ-024 In READ, every 8th sample edge SHALL increment the pointer modulo NUM_REGS and reload the tx shift register from reg[new pointer].
REQ-025 Each shift edge SHALL set MISO <= tx_sh[7] and tx_sh <= tx_sh << 1; MISO SHALL be 0 during ADDR and WRITE.
REQ-026 A write burst longer than NUM_REGS bytes SHALL wrap and overwrite from the start pointer.
REQ-027 A CS rise in any non-IDLE state SHALL return the FSM to IDLE on the next clk; a partial byte SHALL be discarded with no wr_en; MISO is driven 0.
REQ-028 frame_done SHALL pulse on that CS rise only if at least 8 sample edges occurred in the frame.
REQ-029 SCLK edges while CS is high SHALL be ignored.
REQ-030 A CS fall and a CS rise detected on the same clk (glitch) SHALL leave the FSM in IDLE.

Reset
REQ-031 While reset=0 at a clk edge: FSM=IDLE, all registers=8'h00, MISO=0, wr_en=0, wr_addr=0, wr_data=0, frame_done=0, busy=0, synchronizers loaded with the idle level (CS=1, SCLK=CPOL of MODE).
REQ-032 Reset asserted mid-frame SHALL abort the frame; after release the block waits for a fresh CS fall.

Structure
REQ-033 Package spi_pkg SHALL hold the state enum, the MODE field positions, NUM_REGS_DEF=4 and the ADDR/RW bit positions.
REQ-034 Sub-module spi_edge_sync SHALL implement the synchronizer and the rise/fall pulse detector; it is instantiated for SCLK and CS.

Verification
REQ-035 Mode 0, SCLK=clk/10, send 0x80,0xA5 -> wr_en once, wr_addr=0, wr_data=0xA5, regs_o[7:0]=0xA5, frame_done pulse.
REQ-036 Mode 3, registers preloaded 11,22,33,44, send 0x02 followed by 3 dummy bytes -> MISO bytes 0x33,0x44,0x11.
REQ-037 Modes 1 and 2, write burst 0x81 then 01..05 -> reg1=05, reg2=02, reg3=03, reg0=04; five wr_en pulses.
REQ-038 Mode 0, CS rise after 5 bits of the data byte following 0x80 -> no wr_en for that byte, regs unchanged, frame_done pulse (address byte complete).
REQ-039 Reset low mid-READ -> MISO=0 and regs_o=0 the next clk; a following frame 0x00 + dummy returns 0x00.
REQ-040 SCLK toggling with CS high, then a 0x83,0x7E frame -> only reg3=0x7E changes.
